// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter on a valid/ready memory bus: byte writes queue into a DEPTH-entry FIFO.
// Ready one cycle after acceptance (tx falls two edges after an idle write); writes to a full FIFO wait until a pop frees a slot.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        uart_tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] cyc_cnt, cyc_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    head, push_dat, pend_dat;
    logic          tx_nxt, pop, push, pend, pend_set;
    logic          full, busy, last_cyc, ack_other, is_read;
    logic          unused_ok;

    assign unused_ok = &{1'b0, memory_instr, memory_addr, memory_wdata[31:8]};

    assign full     = (count == (AW+1)'(DEPTH));
    assign busy     = (state != IDLE) || (count != '0);
    assign last_cyc = (cyc_cnt == CW'(CLKS_PER_BIT - 1));
    assign head     = fifo_mem[rd_ptr];

    // A write that finds the FIFO full parks here and retries every cycle.
    assign push_dat  = pend ? pend_dat : memory_wdata[7:0];
    assign push      = (pend || (memory_valid && memory_wstrb[0])) && !full;
    assign pend_set  = memory_valid && !pend && memory_wstrb[0] && full;
    assign ack_other = memory_valid && !pend && !memory_wstrb[0];
    assign is_read   = memory_valid && !pend && (memory_wstrb == 4'b0000);

    always_ff @(posedge clock) begin
        if (reset) begin
            pend         <= 1'b0;
            pend_dat     <= '0;
            memory_ready <= 1'b0;
            memory_rdata <= '0;
        end else begin
            memory_ready <= push || ack_other;
            memory_rdata <= is_read ? {30'b0, busy, full} : 32'b0;
            if (pend_set) begin
                pend     <= 1'b1;
                pend_dat <= memory_wdata[7:0];
            end else if (push) begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            uart_tx <= tx_nxt;
        end
    end

    // tx_nxt reflects the current state, so the line lags the FSM by one register stage.
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                cyc_nxt = '0;
                bit_nxt = '0;
                if (count != '0) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (last_cyc) begin
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end
            DATA: begin
                tx_nxt = shift[0];
                if (last_cyc) begin
                    cyc_nxt   = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    bit_nxt   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (last_cyc) begin
                    cyc_nxt = '0;
                    bit_nxt = '0;
                    if (count != '0) begin
                        pop       = 1'b1;
                        shift_nxt = head;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench: fast instance (4 clocks/bit) for function, default instance for baud timing.
module tb_uart_tx_buffered;
    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        tx;
    logic        d_valid;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_tx;
    logic        mon_en;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [7:0] rx_q[$];
    int   st_q[$];

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .memory_valid(valid), .memory_instr(1'b0),
        .memory_addr(32'h0100_0000), .memory_wdata(wdata), .memory_wstrb(wstrb),
        .memory_rdata(rdata), .memory_ready(ready), .uart_tx(tx)
    );

    uart_tx_buffered dut_def (
        .clock(clock), .reset(reset), .memory_valid(d_valid), .memory_instr(1'b0),
        .memory_addr(32'h0100_0000), .memory_wdata(d_wdata), .memory_wstrb(d_wstrb),
        .memory_rdata(d_rdata), .memory_ready(d_ready), .uart_tx(d_tx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_req(input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [31:0] rd, output int acc);
        @(negedge clock);
        valid = 1'b1;
        wdata = d;
        wstrb = s;
        @(posedge clock); #1;
        acc   = cyc;
        valid = 1'b0;
        wdata = '0;
        wstrb = '0;
        lat   = 1;
        while (ready !== 1'b1 && lat < 300) begin
            @(posedge clock); #1;
            lat++;
        end
        rd = rdata;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clock);
            k++;
        end
        check(tag, rx_q.size(), n);
    endtask

    function automatic logic [31:0] got_byte(input int i);
        return (rx_q.size() > i) ? {24'b0, rx_q[i]} : 32'hDEAD;
    endfunction

    function automatic int got_start(input int i);
        return (st_q.size() > i) ? st_q[i] : -1;
    endfunction

    // Frame decoder: samples each bit in its middle, starting at the first low cycle.
    initial begin : mon
        logic [7:0] b;
        int s;
        forever begin
            @(posedge clock); #2;
            if (mon_en && tx === 1'b0) begin
                s = cyc;
                repeat (2) @(posedge clock);
                #2;
                check("mon_start_mid", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clock);
                    #2;
                    b[i] = tx;
                end
                repeat (CPB) @(posedge clock);
                #2;
                check("mon_stop_bit", tx, 1);
                rx_q.push_back(b);
                st_q.push_back(s);
            end
        end
    end

    initial begin
        int lat, acc, acc0;
        logic [31:0] rd;
        logic [9:0]  fr;
        logic        exp_b, high;

        reset = 1'b1; valid = 1'b0; wdata = '0; wstrb = '0; mon_en = 1'b0;
        d_valid = 1'b0; d_wdata = '0; d_wstrb = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", ready, 0);
        check("rst_rdata", rdata, 0);
        check("rst_def_tx", d_tx, 1);
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;

        bus_req(32'h0, 4'b0000, lat, rd, acc);
        check("idle_read_lat", lat, 1);
        check("idle_status", rd, 32'h0);

        // T1: single 0x55 frame, cycle by cycle
        rx_q.delete(); st_q.delete();
        bus_req(32'h55, 4'b0001, lat, rd, acc);
        check("t1_lat", lat, 1);
        fr = {1'b1, 8'h55, 1'b0};
        for (int c = 1; c <= 42; c++) begin
            @(posedge clock); #1;
            exp_b = (c >= 2 && c <= 41) ? fr[(c - 2) / CPB] : 1'b1;
            check($sformatf("t1_tx_c%0d", c), tx, exp_b);
        end
        wait_frames(1, 20, "t1_frames");
        check("t1_byte", got_byte(0), 32'h55);
        check("t1_start_cycle", got_start(0), acc + 2);
        bus_req(32'h0, 4'b0000, lat, rd, acc);
        check("t1_status_idle", rd, 32'h0);

        // T2: four consecutive writes, frames contiguous
        rx_q.delete(); st_q.delete();
        acc0 = 0;
        for (int i = 0; i < 4; i++) begin
            bus_req(32'(i + 1), 4'b0001, lat, rd, acc);
            if (i == 0) acc0 = acc;
            check($sformatf("t2_lat%0d", i), lat, 1);
        end
        wait_frames(4, 400, "t2_frames");
        check("t2_first_start", got_start(0), acc0 + 2);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_byte%0d", i), got_byte(i), 32'(i + 1));
            if (i > 0) check($sformatf("t2_gap%0d", i), got_start(i) - got_start(i - 1), 10 * CPB);
        end
        repeat (5) @(posedge clock);

        // T3/T4: first byte goes straight to the serializer, next four fill the FIFO,
        // the sixth write meets a full FIFO and waits for the pop at the end of frame one.
        rx_q.delete(); st_q.delete();
        for (int i = 0; i < 5; i++) begin
            bus_req(32'h10 + 32'(i), 4'b0001, lat, rd, acc);
            check($sformatf("t3_lat%0d", i), lat, 1);
        end
        bus_req(32'h0, 4'b0000, lat, rd, acc);
        check("t4_full_read_lat", lat, 1);
        check("t4_full_status", rd, 32'h3);
        bus_req(32'h15, 4'b0001, lat, rd, acc);
        check("t3_blocked_lat", lat, 37);
        wait_frames(5, 400, "t3_five_frames");
        repeat (10) @(posedge clock);
        bus_req(32'h0, 4'b0000, lat, rd, acc);
        check("t4_busy_status", rd, 32'h2);
        wait_frames(6, 200, "t3_frames");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_byte%0d", i), got_byte(i), 32'h10 + 32'(i));
            if (i > 0) check($sformatf("t3_gap%0d", i), got_start(i) - got_start(i - 1), 10 * CPB);
        end
        repeat (5) @(posedge clock);
        bus_req(32'h0, 4'b0000, lat, rd, acc);
        check("t4_drained_status", rd, 32'h0);

        // T5: reset at frame cycle 15
        bus_req(32'hA5, 4'b0001, lat, rd, acc);
        check("t5_lat", lat, 1);
        repeat (16) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("t5_tx_after_reset", tx, 1);
        check("t5_ready_after_reset", ready, 0);
        reset = 1'b0;
        high = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock); #1;
            if (tx !== 1'b1) high = 1'b0;
        end
        check("t5_no_frame", high, 1);
        bus_req(32'h0, 4'b0000, lat, rd, acc);
        check("t5_status", rd, 32'h0);

        // T6: write without byte-0 strobe
        rx_q.delete(); st_q.delete();
        bus_req(32'h77, 4'b0010, lat, rd, acc);
        check("t6_lat", lat, 1);
        check("t6_rdata", rd, 32'h0);
        high = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clock); #1;
            if (tx !== 1'b1) high = 1'b0;
        end
        check("t6_tx_idle", high, 1);
        bus_req(32'h0, 4'b0000, lat, rd, acc);
        check("t6_status", rd, 32'h0);
        check("t6_no_rx", rx_q.size(), 0);

        // Default parameters: 868 clocks per bit, byte 0x55
        @(negedge clock);
        d_valid = 1'b1;
        d_wdata = 32'h55;
        d_wstrb = 4'b0001;
        @(posedge clock); #1;
        d_valid = 1'b0;
        d_wstrb = 4'b0000;
        check("def_ready", d_ready, 1);
        check("def_rdata", d_rdata, 0);
        for (int c = 1; c <= 8682; c++) begin
            @(posedge clock); #1;
            case (c)
                1:       check("def_c1_idle", d_tx, 1);
                2:       check("def_start_first", d_tx, 0);
                869:     check("def_start_last", d_tx, 0);
                870:     check("def_bit0_first", d_tx, 1);
                1737:    check("def_bit0_last", d_tx, 1);
                1738:    check("def_bit1_first", d_tx, 0);
                7813:    check("def_bit7_last", d_tx, 0);
                7814:    check("def_stop_first", d_tx, 1);
                8682:    check("def_idle_after", d_tx, 1);
                default: ;
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
